// File: rtl/jtpopeye_dma_pkg.sv
// Shared types and constants for the Popeye object DMA sequencer.
// JTPOPEYE_DMA_DBLBUF_EN widens the object buffer address by one bank bit.
package jtpopeye_pkg;

  localparam int OBJ_AW      = 10;
  localparam int DMA_DEF_LEN = 1024;

`ifdef JTPOPEYE_DMA_DBLBUF_EN
  localparam int OBJ_OUT_AW = OBJ_AW + 1;
`else
  localparam int OBJ_OUT_AW = OBJ_AW;
`endif

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    FLUSH,
    REL
  } dma_state_e;

endpackage

// File: rtl/jtpopeye_dma_if.sv
// Z80 bus arbitration and main-RAM DMA read port shared by the DMA and the CPU board.
interface jtpopeye_dma_if;
  import jtpopeye_pkg::*;

  logic              busrq_n;
  logic              busak_n;
  logic              dma_cs;
  logic [OBJ_AW-1:0] AD_DMA;
  logic [7:0]        DD_DMA;

  modport master (
    output busrq_n,
    output dma_cs,
    output AD_DMA,
    input  busak_n,
    input  DD_DMA
  );

  modport slave (
    input  busrq_n,
    input  dma_cs,
    input  AD_DMA,
    output busak_n,
    output DD_DMA
  );

endinterface

// File: rtl/jtpopeye_dma.sv
// Object DMA: on each VB rise, grab the Z80 bus and copy DMA_LEN bytes of main RAM
// into the object buffer. Define JTPOPEYE_DMA_DBLBUF_EN for a ping-pong buffer with obj_bank.
module jtpopeye_dma
  import jtpopeye_pkg::*;
#(
  parameter int unsigned       DMA_LEN    = DMA_DEF_LEN,
  parameter logic [OBJ_AW-1:0] START_ADDR = 10'h000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  input  logic                  VB,
  jtpopeye_dma_if.master        bus,
  output logic                  obj_we,
  output logic [OBJ_OUT_AW-1:0] obj_addr,
  output logic [7:0]            obj_data,
`ifdef JTPOPEYE_DMA_DBLBUF_EN
  output logic                  obj_bank,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam logic [OBJ_AW-1:0] LAST_IDX = OBJ_AW'(DMA_LEN - 1);

  dma_state_e            state_q, state_d;
  logic                  vbl_q, vbl_d;
  logic [OBJ_AW-1:0]     cnt_q, cnt_d;
  logic                  busrq_n_q, busrq_n_d;
  logic                  dma_cs_q, dma_cs_d;
  logic [OBJ_AW-1:0]     ad_q, ad_d;
  logic                  obj_we_q, obj_we_d;
  logic [OBJ_OUT_AW-1:0] obj_addr_q, obj_addr_d;
  logic [7:0]            obj_data_q, obj_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
`ifdef JTPOPEYE_DMA_DBLBUF_EN
  logic                  bank_q, bank_d;
`endif

  logic                  trig;
  logic [OBJ_AW-1:0]     wr_idx;

  assign trig = VB & ~vbl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vbl_q      <= 1'b0;
      cnt_q      <= '0;
      busrq_n_q  <= 1'b1;
      dma_cs_q   <= 1'b0;
      ad_q       <= START_ADDR;
      obj_we_q   <= 1'b0;
      obj_addr_q <= '0;
      obj_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef JTPOPEYE_DMA_DBLBUF_EN
      bank_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      vbl_q      <= vbl_d;
      cnt_q      <= cnt_d;
      busrq_n_q  <= busrq_n_d;
      dma_cs_q   <= dma_cs_d;
      ad_q       <= ad_d;
      obj_we_q   <= obj_we_d;
      obj_addr_q <= obj_addr_d;
      obj_data_q <= obj_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
`ifdef JTPOPEYE_DMA_DBLBUF_EN
      bank_q     <= bank_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    vbl_d      = vbl_q;
    cnt_d      = cnt_q;
    busrq_n_d  = busrq_n_q;
    dma_cs_d   = dma_cs_q;
    ad_d       = ad_q;
    obj_we_d   = 1'b0;
    obj_addr_d = obj_addr_q;
    obj_data_d = obj_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    overrun_d  = overrun_q;
`ifdef JTPOPEYE_DMA_DBLBUF_EN
    bank_d     = bank_q;
`endif
    wr_idx     = '0;

    if (cen) begin
      vbl_d     = VB;
      done_d    = 1'b0;
      overrun_d = trig && (state_q != IDLE);

      unique case (state_q)
        IDLE: begin
          if (trig) begin
            state_d   = REQ;
            busy_d    = 1'b1;
            busrq_n_d = 1'b0;
          end
        end
        REQ: begin
          if (!bus.busak_n) begin
            state_d  = XFER;
            cnt_d    = '0;
            dma_cs_d = 1'b1;
          end
        end
        XFER: begin
          // Data on DD_DMA now belongs to the address issued on the previous cen.
          ad_d = START_ADDR + cnt_q;
          if (cnt_q != '0) begin
            obj_we_d = 1'b1;
            wr_idx   = cnt_q - OBJ_AW'(1);
          end
          cnt_d = cnt_q + OBJ_AW'(1);
          if (cnt_q == LAST_IDX) state_d = FLUSH;
        end
        FLUSH: begin
          obj_we_d  = 1'b1;
          wr_idx    = LAST_IDX;
          dma_cs_d  = 1'b0;
          busrq_n_d = 1'b1;
          state_d   = REL;
        end
        REL: begin
          if (bus.busak_n) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef JTPOPEYE_DMA_DBLBUF_EN
            bank_d  = ~bank_q;
`endif
          end
        end
        default: state_d = IDLE;
      endcase

      if (obj_we_d) begin
`ifdef JTPOPEYE_DMA_DBLBUF_EN
        obj_addr_d = {~bank_q, wr_idx};
`else
        obj_addr_d = wr_idx;
`endif
        obj_data_d = bus.DD_DMA;
      end
    end
  end

  assign bus.busrq_n = busrq_n_q;
  assign bus.dma_cs  = dma_cs_q;
  assign bus.AD_DMA  = ad_q;
  assign obj_we      = obj_we_q;
  assign obj_addr    = obj_addr_q;
  assign obj_data    = obj_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
`ifdef JTPOPEYE_DMA_DBLBUF_EN
  assign obj_bank    = bank_q;
`endif

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Scoreboard bench for jtpopeye_dma: two lockstep instances (START 0x100 and wrapping 0x3FE).
module tb_jtpopeye_dma;
  import jtpopeye_pkg::*;

  typedef struct {
    logic [OBJ_OUT_AW-1:0] addr;
    logic [7:0]            data;
    logic [OBJ_AW-1:0]     ad;
  } wr_t;

  wr_t exp0[$];
  wr_t exp1[$];

  logic clk = 1'b0, rst = 1'b1, cen = 1'b0, VB = 1'b0, busak_n = 1'b1;
  int   checks = 0, failures = 0;
  int   wr_cnt0 = 0, wr_cnt1 = 0, done_cnt = 0, ovr_cnt = 0;
  logic bank_m = 1'b0, done_p = 1'b0, ovr_p = 1'b0;

  logic                  we0, we1, busy0, busy1, done0, done1, ovr0, ovr1;
  logic [OBJ_OUT_AW-1:0] addr0, addr1;
  logic [7:0]            data0, data1;
`ifdef JTPOPEYE_DMA_DBLBUF_EN
  logic                  bank0, bank1;
`endif

  always #5 clk = ~clk;
  always @(negedge clk) cen = ~cen;

  function automatic logic [7:0] ram_f(input logic [OBJ_AW-1:0] a);
    if (a[9:8] == 2'b01) return 8'(8'hA0 + a[7:0]);
    return 8'(8'h30 + a[7:0] + {a[9:8], 6'b0});
  endfunction

  jtpopeye_dma_if bus0 ();
  jtpopeye_dma_if bus1 ();
  assign bus0.busak_n = busak_n;
  assign bus1.busak_n = busak_n;
  assign bus0.DD_DMA  = ram_f(bus0.AD_DMA);
  assign bus1.DD_DMA  = ram_f(bus1.AD_DMA);

  jtpopeye_dma #(.DMA_LEN(4), .START_ADDR(10'h100)) u_dut (
    .clk(clk), .rst(rst), .cen(cen), .VB(VB), .bus(bus0),
    .obj_we(we0), .obj_addr(addr0), .obj_data(data0),
`ifdef JTPOPEYE_DMA_DBLBUF_EN
    .obj_bank(bank0),
`endif
    .busy(busy0), .done(done0), .overrun(ovr0)
  );

  jtpopeye_dma #(.DMA_LEN(4), .START_ADDR(10'h3FE)) u_wrap (
    .clk(clk), .rst(rst), .cen(cen), .VB(VB), .bus(bus1),
    .obj_we(we1), .obj_addr(addr1), .obj_data(data1),
`ifdef JTPOPEYE_DMA_DBLBUF_EN
    .obj_bank(bank1),
`endif
    .busy(busy1), .done(done1), .overrun(ovr1)
  );

  function automatic logic [OBJ_OUT_AW-1:0] exp_addr(input int i);
`ifdef JTPOPEYE_DMA_DBLBUF_EN
    return {~bank_m, OBJ_AW'(i)};
`else
    return OBJ_OUT_AW'(i);
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Expected writes: data from the RAM table, AD_DMA as seen when each write lands.
  task automatic push_exp(input int n);
    logic [7:0]        d0[4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    logic [7:0]        d1[4] = '{8'hEE, 8'hEF, 8'h30, 8'h31};
    logic [OBJ_AW-1:0] a0[4] = '{10'h101, 10'h102, 10'h103, 10'h103};
    logic [OBJ_AW-1:0] a1[4] = '{10'h3FF, 10'h000, 10'h001, 10'h001};
    for (int i = 0; i < n; i++) begin
      exp0.push_back('{addr: exp_addr(i), data: d0[i], ad: a0[i]});
      exp1.push_back('{addr: exp_addr(i), data: d1[i], ad: a1[i]});
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (we0) begin
      wr_cnt0++;
      checks++;
      if (exp0.size() == 0) begin
        failures++;
        $display("FAIL wr0_unexpected actual addr=%0h data=%0h required none", addr0, data0);
      end else begin
        e = exp0.pop_front();
        if (addr0 !== e.addr || data0 !== e.data || bus0.AD_DMA !== e.ad) begin
          failures++;
          $display("FAIL wr0 actual addr=%0h data=%0h ad=%0h required addr=%0h data=%0h ad=%0h",
                   addr0, data0, bus0.AD_DMA, e.addr, e.data, e.ad);
        end
      end
    end
    if (we1) begin
      wr_cnt1++;
      checks++;
      if (exp1.size() == 0) begin
        failures++;
        $display("FAIL wr1_unexpected actual addr=%0h data=%0h required none", addr1, data1);
      end else begin
        e = exp1.pop_front();
        if (addr1 !== e.addr || data1 !== e.data || bus1.AD_DMA !== e.ad) begin
          failures++;
          $display("FAIL wr1 actual addr=%0h data=%0h ad=%0h required addr=%0h data=%0h ad=%0h",
                   addr1, data1, bus1.AD_DMA, e.addr, e.data, e.ad);
        end
      end
    end
    if (done0 && !done_p) done_cnt++;
    if (ovr0 && !ovr_p) ovr_cnt++;
    done_p = done0;
    ovr_p  = ovr0;
    if (!rst) begin
      checks++;
      if (done1 !== done0 || ovr1 !== ovr0 || busy1 !== busy0
`ifdef JTPOPEYE_DMA_DBLBUF_EN
          || bank1 !== bank0
`endif
         ) begin
        failures++;
        $display("FAIL lockstep actual done/ovr/busy=%b%b%b required %b%b%b",
                 done1, ovr1, busy1, done0, ovr0, busy0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    while (cen !== 1'b1) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int gdly, input bit ovr);
    int w0, w1, d0, o0, n;
    bit ok;
    w0 = wr_cnt0; w1 = wr_cnt1; d0 = done_cnt; o0 = ovr_cnt;
    push_exp(4);
    VB = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus0.busrq_n !== 1'b0 && n < 10);
    check("busrq_low", bus0.busrq_n, 0);
    check("busy_req", busy0, 1);
    ok = 1'b1;
    repeat (gdly) begin
      tick();
      if (bus0.dma_cs !== 1'b0 || busy0 !== 1'b1 || bus0.busrq_n !== 1'b0 || wr_cnt0 != w0) ok = 1'b0;
    end
    check("grant_wait_hold", ok, 1);
    busak_n = 1'b0;
    if (ovr) begin
      tick(); VB = 1'b0;
      tick(); VB = 1'b1;
    end
    n = 0;
    while (bus0.busrq_n !== 1'b1 && n < 20) begin tick(); n++; end
    check("bus_release", bus0.busrq_n, 1);
    check("flush_dma_cs", bus0.dma_cs, 0);
    check("flush_last_we", we0, 1);
    check("flush_last_addr", addr0, exp_addr(3));
    check("no_done_before_busak", done_cnt - d0, 0);
    tick();
    busak_n = 1'b1;
    n = 0;
    while (done_cnt == d0 && n < 20) begin tick(); n++; end
    repeat (4) tick();
    VB = 1'b0;
    check("writes0", wr_cnt0 - w0, 4);
    check("writes1", wr_cnt1 - w1, 4);
    check("done_once", done_cnt - d0, 1);
    check("overrun_cnt", ovr_cnt - o0, ovr ? 1 : 0);
    check("busy_idle", busy0, 0);
    bank_m = ~bank_m;
`ifdef JTPOPEYE_DMA_DBLBUF_EN
    check("obj_bank", bank0, bank_m);
`endif
    repeat (2) tick();
  endtask

  task automatic reset_test();
    int w0;
    w0 = wr_cnt0;
    push_exp(1);
    VB = 1'b1;
    tick();
    check("rst_busrq_low", bus0.busrq_n, 0);
    busak_n = 1'b0;
    repeat (3) tick();
    check("rst_pre_we", we0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busrq", bus0.busrq_n, 1);
    check("rst_dma_cs", bus0.dma_cs, 0);
    check("rst_busy", busy0, 0);
    check("rst_we", we0, 0);
    rst = 1'b0;
    busak_n = 1'b1;
    VB = 1'b0;
    bank_m = 1'b0;
    repeat (10) tick();
    check("rst_no_more_writes", wr_cnt0 - w0, 1);
    check("rst_busy_after", busy0, 0);
    check("rst_queue_empty", exp0.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("reset_busrq", bus0.busrq_n, 1);
    check("reset_dma_cs", bus0.dma_cs, 0);
    check("reset_ad0", bus0.AD_DMA, 10'h100);
    check("reset_ad1", bus1.AD_DMA, 10'h3FE);
    check("reset_we", we0, 0);
    check("reset_addr", addr0, 0);
    check("reset_data", data0, 0);
    check("reset_busy", busy0, 0);
    check("reset_done", done0, 0);
    check("reset_overrun", ovr0, 0);
`ifdef JTPOPEYE_DMA_DBLBUF_EN
    check("reset_bank", bank0, 0);
`endif
    rst = 1'b0;
    repeat (3) tick();

    run_frame(2, 1'b0);
    run_frame(50, 1'b0);
    run_frame(1, 1'b1);
    run_frame(0, 1'b0);
    reset_test();
    run_frame(2, 1'b0);

    check("queue0_empty", exp0.size(), 0);
    check("queue1_empty", exp1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtpopeye_dma.md
Name: jtpopeye_dma

Overview:
- Sprite/object DMA sequencer for the Popeye main board.
- On each vertical-blank start it takes the main Z80 off the bus via BUSRQ/BUSAK.
- It then sweeps the object area of main RAM through the DMA address port (dma_cs/AD_DMA/DD_DMA) and copies each byte into the video object buffer.
- When the sweep is done it returns the bus to the CPU. It sits between jtpopeye_main and the object video logic.

Parameters:
- DMA_LEN, 1024: number of bytes transferred per frame; legal range 1..1024.
- START_ADDR, 10'h000: first AD_DMA address of the sweep; the address wraps modulo 1024.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- cen  in  1  CPU clock enable; all state advances only when cen=1, except rst
- VB  in  1  vertical blank; a rising edge sampled on cen starts a transfer
- busrq_n  out  1  bus request to the Z80, active low
- busak_n  in  1  bus acknowledge from the Z80, active low
- dma_cs  out  1  selects the DMA address path in main RAM
- AD_DMA  out  10  DMA read address into main RAM
- DD_DMA  in  8  RAM read data; valid one cen after its AD_DMA is presented
- obj_we  out  1  object buffer write strobe, one clk wide, qualified by cen
- obj_addr  out  10  object buffer write address, equal to byte index 0..DMA_LEN-1
- obj_data  out  8  object buffer write data
- busy  out  1  high from trigger until bus release completes
- done  out  1  one-cen pulse when the transfer is complete
- overrun  out  1  one-cen pulse when a VB edge arrives while busy

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: busrq_n=1, dma_cs=0, AD_DMA=START_ADDR, obj_we=0, obj_addr=0, obj_data=0, busy=0, done=0, overrun=0, state=IDLE, VB edge register=0.
- A reset in the middle of a transfer drops busrq_n to 1 and dma_cs to 0 on the same edge. Partial buffer contents are not cleared.
- Edge detection: VBl<=VB on cen. trig = VB & ~VBl.
- IDLE: on trig, go to REQ and set busy=1 and busrq_n=0.
- REQ: hold busrq_n=0 until busak_n=0 is sampled on cen, then go to XFER with cnt=0 and dma_cs=1.
  - No timeout; the Z80 always grants.
- XFER: each cen, AD_DMA=START_ADDR+cnt (mod 1024).
  - When cnt>0, obj_we=1, obj_addr=cnt-1, obj_data=DD_DMA. This is the 1-cen RAM read pipeline.
  - cnt increments each cen. After the address for cnt=DMA_LEN-1 is issued, go to FLUSH.
- FLUSH: one cen. Write the last byte (obj_addr=DMA_LEN-1), then set dma_cs=0 and busrq_n=1 and go to REL.
- REL: wait for busak_n=1 sampled on cen. Then go to IDLE with busy=0 and pulse done.
- Totals: exactly DMA_LEN writes per transfer, in ascending order. DMA_LEN=1 gives XFER of one cen, then FLUSH.
- Latency: the first obj_we comes 2 cen after grant is sampled.
- Overrun: a trig while in any state other than IDLE pulses overrun and is otherwise ignored; it is not queued.
  - A trig on the same cen that REL returns to IDLE also counts as overrun.
- cen=0: all outputs hold, except obj_we, which is forced to 0.
- busak_n going high during XFER or FLUSH is a protocol error. The block ignores it and continues.

Optional Feature:
- Macro: JTPOPEYE_DMA_DBLBUF_EN.
- Defined: adds output obj_bank (1 bit, reset 0). obj_addr is widened to 11 bits as {~obj_bank, index}.
  - obj_bank toggles on the done pulse, so video reads the completed bank while the next frame fills the other.
- Undefined: no obj_bank port, obj_addr is 10 bits, and a single buffer is overwritten in place.

Decomposition:
- Shared package jtpopeye_pkg holds:
  - the state encoding typedef (IDLE, REQ, XFER, FLUSH, REL);
  - constant OBJ_AW=10;
  - constant DMA_DEF_LEN=1024.
- No sub-module is needed. The VB edge detector is inline.

Test Plan:
- DMA_LEN=4, START_ADDR=10'h100, RAM model bytes A0..A3 at 0x100..0x103, busak_n granted 2 cen after request -> obj writes (0,A0),(1,A1),(2,A2),(3,A3) in order; busrq_n returns to 1 after the FLUSH cen; done pulses once after busak_n=1.
- Grant delayed 50 cen -> dma_cs stays 0 and no obj_we during the wait; busy=1 throughout.
- Second VB rising edge during XFER -> overrun pulses once and exactly 4 writes occur; the next VB edge in IDLE starts a fresh transfer.
- START_ADDR=10'h3FE, DMA_LEN=4 -> AD_DMA sequence 3FE, 3FF, 000, 001; obj_addr 0..3.
- rst asserted at cnt=2 -> busrq_n=1, dma_cs=0, busy=0 on the next clk; no further writes.
- With JTPOPEYE_DMA_DBLBUF_EN defined, two frames -> frame 1 writes obj_addr 0x400..0x403, frame 2 writes 0x000..0x003; obj_bank reads 1 then 0.
